// File: rtl/cordic_angle_sweeper.sv
// cordic_angle_sweeper
//  Stimulus stage for the CORDIC sine/cosine core. Steps a signed 16.16 radian
//  angle from start_angle by step for num_points points, keeping it wrapped
//  into [-pi, pi). Each angle is held on rad for SETTLE_CYC cycles, then
//  sample_valid pulses with the point index.
// Ports
//  clk, rst        clock (rising edge), synchronous active-high reset
//  start, abort    begin sweep (IDLE only) / terminate sweep
//  start_angle     signed 16.16 first angle, must be in [-PI_Q, PI_Q)
//  step            signed 16.16 increment, |step| < PI_Q
//  num_points      points per sweep, 1..65535
//  rad             angle driven to the CORDIC core
//  sample_valid    1-cycle pulse: core outputs for point_idx are valid
//  point_idx       index of the current angle
//  busy            high while settling/sampling
//  done            1-cycle pulse after the final sample
//  err             1-cycle pulse when a start request has bad parameters
module cordic_angle_sweeper #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int          PI_Q       = 205887,
    parameter int          TWO_PI_Q   = 411775
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic signed [31:0] start_angle,
    input  logic signed [31:0] step,
    input  logic        [15:0] num_points,
    output logic signed [31:0] rad,
    output logic               sample_valid,
    output logic        [15:0] point_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic signed [32:0] PI_S     = 33'(PI_Q);
    localparam logic signed [32:0] NEG_PI_S = 33'(-PI_Q);
    localparam logic signed [32:0] TWO_PI_S = 33'(TWO_PI_Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] rad_d;
    logic        [15:0] idx_d;
    logic signed [31:0] step_q, step_d;
    logic        [15:0] num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sample_valid_d, busy_d, done_d, err_d;

    logic signed [32:0] sa_ext, st_ext, sum, wrapped;
    logic               params_ok;

    // Start request validation on the live inputs
    assign sa_ext    = 33'(start_angle);
    assign st_ext    = 33'(step);
    assign params_ok = (num_points != 16'd0) &&
                       (st_ext > NEG_PI_S) && (st_ext < PI_S) &&
                       (sa_ext >= NEG_PI_S) && (sa_ext < PI_S);

    // Next angle with one wrap correction; |step| < pi keeps one correction enough
    assign sum = 33'(rad) + 33'(step_q);
    always_comb begin
        wrapped = sum;
        if (sum >= PI_S) begin
            wrapped = sum - TWO_PI_S;
        end else if (sum < NEG_PI_S) begin
            wrapped = sum + TWO_PI_S;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rad          <= '0;
            point_idx    <= '0;
            step_q       <= '0;
            num_q        <= '0;
            cnt_q        <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            rad          <= rad_d;
            point_idx    <= idx_d;
            step_q       <= step_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            sample_valid <= sample_valid_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        rad_d   = rad;
        idx_d   = point_idx;
        step_d  = step_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (params_ok) begin
                        step_d  = step;
                        num_d   = num_points;
                        rad_d   = start_angle;
                        idx_d   = '0;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // abort takes priority over advancing to the next point
                if (abort) begin
                    state_d = S_IDLE;
                end else if (point_idx == num_q - 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    rad_d   = 32'(wrapped);
                    idx_d   = point_idx + 16'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulses/levels are registered views of the state being entered
        sample_valid_d = (state_d == S_SAMPLE);
        busy_d         = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d         = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_cordic_angle_sweeper.sv
// Testbench for cordic_angle_sweeper: vector table of sweeps plus hand-written
// reset, abort and restart sequences; expected samples queued at start time.
module tb_cordic_angle_sweeper;

    localparam int PER  = 3;        // SETTLE_CYC + 1
    localparam int PI   = 205887;
    localparam int TWO  = 411775;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic signed [31:0] start_angle;
    logic signed [31:0] step;
    logic        [15:0] num_points;
    logic signed [31:0] rad;
    logic               sample_valid;
    logic        [15:0] point_idx;
    logic               busy;
    logic               done;
    logic               err;

    cordic_angle_sweeper #(
        .SETTLE_CYC (2),
        .PI_Q       (PI),
        .TWO_PI_Q   (TWO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .start_angle  (start_angle),
        .step         (step),
        .num_points   (num_points),
        .rad          (rad),
        .sample_valid (sample_valid),
        .point_idx    (point_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] sa;
        logic signed [31:0] st;
        logic        [15:0] n;
        bit                 bad;
        logic signed [31:0] last;
    } vec_t;

    typedef struct {
        logic        [15:0] idx;
        logic signed [31:0] rad;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic signed [31:0] prev_rad;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic signed [31:0] wrap_add(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s >= PI) s = s - TWO;
        else if (s < -PI) s = s + TWO;
        return 32'(s);
    endfunction

    function automatic void push_model(input logic signed [31:0] sa,
                                       input logic signed [31:0] st, input int n);
        logic signed [31:0] a;
        exp_t e;
        a = sa;
        for (int i = 0; i < n; i++) begin
            e.idx = 16'(i);
            e.rad = a;
            sb.push_back(e);
            a = wrap_add(a, st);
        end
    endfunction

    // Pops one expected sample and compares it; returns the popped index
    task automatic check_sample(output int idx);
        exp_t e;
        idx = -1;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sample: got idx %0d expected none", point_idx);
        end else begin
            e = sb.pop_front();
            idx = int'(e.idx);
            chk("sample_idx", point_idx, e.idx);
            chk("sample_rad", rad, e.rad);
            chk("sample_excl_done", done, 0);
        end
    endtask

    task automatic drive_start(input logic signed [31:0] sa, input logic signed [31:0] st,
                               input int n, input bit model);
        @(negedge clk);
        start_angle = sa;
        step        = st;
        num_points  = 16'(n);
        start       = 1'b1;
        if (model) push_model(sa, st, n);
    endtask

    // Follows a sweep started just before; optional abort during SAMPLE of abort_idx
    task automatic watch(input int n, input int abort_idx);
        bit got_done = 0;
        bit aborted  = 0;
        int idx;
        logic signed [31:0] held = '0;
        for (int c = 1; c <= PER * n + 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort_no_sample", sample_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
                chk("abort_rad_hold", rad, held);
                sb.delete();
                aborted = 1;
                break;
            end
            if (c <= PER * n) chk("busy_in_sweep", busy, 1);
            if (sample_valid) begin
                check_sample(idx);
                chk("sample_timing", c, PER * (idx + 1));
                if (idx == abort_idx) begin
                    abort = 1'b1;
                    held  = rad;
                end
            end
            if (done) begin
                chk("done_timing", c, PER * n + 1);
                chk("done_busy", busy, 0);
                chk("queue_drained", sb.size(), 0);
                got_done = 1;
                break;
            end
        end
        if (!got_done && !aborted) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no done expected done within %0d cycles", PER * n + 4);
        end
    endtask

    task automatic apply_bad(input logic signed [31:0] sa, input logic signed [31:0] st,
                             input int n);
        drive_start(sa, st, n, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_no_sample", sample_valid, 0);
        chk("err_rad_hold", rad, prev_rad);
        @(negedge clk);
        chk("err_single", err, 0);
        chk("err_idle", busy, 0);
    endtask

    initial begin
        tbl[0] = '{sa: 0,       st: 102944,  n: 4, bad: 0, last: -102943};
        tbl[1] = '{sa: -200000, st: -10000,  n: 2, bad: 0, last: 201775};
        tbl[2] = '{sa: 0,       st: 205887,  n: 4, bad: 1, last: 0};
        tbl[3] = '{sa: 0,       st: 1000,    n: 0, bad: 1, last: 0};
        tbl[4] = '{sa: 205887,  st: 1000,    n: 3, bad: 1, last: 0};
        tbl[5] = '{sa: 0,       st: -205887, n: 3, bad: 1, last: 0};
        tbl[6] = '{sa: -205887, st: 205886,  n: 3, bad: 0, last: 205885};
        tbl[7] = '{sa: 205886,  st: 1,       n: 2, bad: 0, last: -205888};
        tbl[8] = '{sa: 1000,    st: 50000,   n: 5, bad: 0, last: 201000};

        // Reset held two cycles with start high
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        start_angle = 32'sd5000; step = 32'sd1000; num_points = 16'd3;
        repeat (2) @(negedge clk);
        chk("rst_rad", rad, 0);
        chk("rst_idx", point_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_stays_idle", busy, 0);
        prev_rad = '0;

        // Table-driven sweeps and rejects
        foreach (tbl[i]) begin
            if (tbl[i].bad) begin
                apply_bad(tbl[i].sa, tbl[i].st, int'(tbl[i].n));
            end else begin
                drive_start(tbl[i].sa, tbl[i].st, int'(tbl[i].n), 1'b1);
                watch(int'(tbl[i].n), -1);
                chk("last_rad", rad, tbl[i].last);
                chk("last_idx", point_idx, tbl[i].n - 16'd1);
                prev_rad = tbl[i].last;
            end
        end

        // Abort during SAMPLE of idx 3, then a fresh sweep is accepted
        drive_start(32'sd0, 32'sd1000, 10, 1'b1);
        watch(10, 3);
        chk("abort_rad_value", rad, 3000);
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_quiet", sample_valid | done | busy, 0);
        end
        drive_start(32'sd500, -32'sd700, 2, 1'b1);
        watch(2, -1);
        chk("after_abort_rad", rad, -200);

        // Single point with start held high: ignored while busy, restarts after done
        begin
            int idx;
            drive_start(32'sd7000, 32'sd123, 1, 1'b1);
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                if (c == 6) start = 1'b0;
                if (c == 5) push_model(32'sd7000, 32'sd123, 1);
                chk("single_sv", sample_valid, (c == 3 || c == 8) ? 1 : 0);
                chk("single_done", done, (c == 4 || c == 9) ? 1 : 0);
                chk("single_busy", busy, (c <= 3 || (c >= 6 && c <= 8)) ? 1 : 0);
                if (sample_valid) check_sample(idx);
            end
            chk("single_queue", sb.size(), 0);
        end

        // Reset mid-sweep with start in the same cycle
        drive_start(32'sd0, 32'sd1000, 5, 1'b0);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("midrst_rad", rad, 0);
        chk("midrst_idx", point_idx, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", sample_valid | done | err, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("midrst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
